// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial-by-nibble ALU: op indices, 74181 function
// codes packed as {S[3:0], M, cin}, FSM states and the op_sel decoder.
package alu_seq_pkg;

  localparam int SLICE_W = 4;

  localparam int OP_ADD = 7;
  localparam int OP_SUB = 6;
  localparam int OP_AND = 5;
  localparam int OP_OR  = 4;
  localparam int OP_XOR = 3;
  localparam int OP_NOT = 2;
  localparam int OP_INC = 1;
  localparam int OP_DEC = 0;

  localparam logic [5:0] CODE_ADD = 6'b1001_0_0;
  localparam logic [5:0] CODE_SUB = 6'b0110_0_1;
  localparam logic [5:0] CODE_AND = 6'b1011_1_0;
  localparam logic [5:0] CODE_OR  = 6'b1110_1_0;
  localparam logic [5:0] CODE_XOR = 6'b0110_1_0;
  localparam logic [5:0] CODE_NOT = 6'b0000_1_0;
  localparam logic [5:0] CODE_INC = 6'b0000_0_1;
  localparam logic [5:0] CODE_DEC = 6'b1111_0_0;
  localparam logic [5:0] CODE_ILL = 6'b0011_1_0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [5:0] decode_op(input logic [7:0] op_sel);
    logic [5:0] code;
    case (op_sel)
      8'b1000_0000: code = CODE_ADD;
      8'b0100_0000: code = CODE_SUB;
      8'b0010_0000: code = CODE_AND;
      8'b0001_0000: code = CODE_OR;
      8'b0000_1000: code = CODE_XOR;
      8'b0000_0100: code = CODE_NOT;
      8'b0000_0010: code = CODE_INC;
      8'b0000_0001: code = CODE_DEC;
      default:      code = CODE_ILL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181-equivalent slice, active-high data and carry.
// c3 is the carry into the slice's top bit, used for signed overflow detection.
module alu181_slice
  import alu_seq_pkg::*;
(
  input  logic [3:0]         s,
  input  logic               m,
  input  logic               cin,
  input  logic [SLICE_W-1:0] a_nib,
  input  logic [SLICE_W-1:0] b_nib,
  output logic [SLICE_W-1:0] f_nib,
  output logic               cout,
  output logic               c3
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] sum;
  logic [3:0] low;

  // Arithmetic mode is g + p + cin; logic mode is the complemented half-sum.
  always_comb begin
    p   = a_nib | (b_nib & {4{s[0]}}) | (~b_nib & {4{s[1]}});
    g   = (a_nib & ~b_nib & {4{s[2]}}) | (a_nib & b_nib & {4{s[3]}});
    sum = {1'b0, g} + {1'b0, p} + {4'b0000, cin};
    low = {1'b0, g[2:0]} + {1'b0, p[2:0]} + {3'b000, cin};
    if (m) begin
      f_nib = ~(p ^ g);
      cout  = 1'b0;
      c3    = 1'b0;
    end else begin
      f_nib = sum[3:0];
      cout  = sum[4];
      c3    = low[3];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one 74181 slice evaluated per cycle, LS nibble first, carry chained.
// Define ALU_OVF_EN to build signed-overflow detection; otherwise ovf is tied low.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal,
  output logic             ovf
);

  localparam int NSL   = WIDTH / SLICE_W;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [5:0]         code_q, code_d;
  logic               ill_op_q, ill_op_d;
  logic               cy_q, cy_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, zero_q, zero_d, illegal_q, illegal_d;
  logic [5:0]         dec_code;
  logic [SLICE_W-1:0] a_nib, b_nib, f_nib;
  logic               slice_cout;
`ifdef ALU_OVF_EN
  logic               slice_c3;
  logic               ovf_q, ovf_d;
`endif

  assign dec_code = decode_op(op_sel);
  assign a_nib    = a_q[{idx_q, 2'b00} +: SLICE_W];
  assign b_nib    = b_q[{idx_q, 2'b00} +: SLICE_W];

  alu181_slice u_slice (
    .s     (code_q[5:2]),
    .m     (code_q[1]),
    .cin   (cy_q),
    .a_nib (a_nib),
    .b_nib (b_nib),
    .f_nib (f_nib),
    .cout  (slice_cout),
`ifdef ALU_OVF_EN
    .c3    (slice_c3)
`else
    .c3    ()
`endif
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    code_d    = code_q;
    ill_op_d  = ill_op_q;
    cy_d      = cy_q;
    idx_d     = idx_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          a_d      = a;
          b_d      = b;
          code_d   = dec_code;
          ill_op_d = !is_onehot(op_sel);
          cy_d     = dec_code[0];
          idx_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        result_d[{idx_q, 2'b00} +: SLICE_W] = f_nib;
        if (!code_q[1]) cy_d = slice_cout;
        idx_d = idx_q + 1'b1;
        // Flags are captured only on the final slice, as the FSM enters DONE.
        if (idx_q == LAST_IDX) begin
          state_d   = ST_DONE;
          carry_d   = !code_q[1] && slice_cout;
          zero_d    = (result_d == '0);
          illegal_d = ill_op_q;
`ifdef ALU_OVF_EN
          ovf_d     = !code_q[1] && (slice_c3 ^ slice_cout);
`endif
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      code_q    <= '0;
      ill_op_q  <= 1'b0;
      cy_q      <= 1'b0;
      idx_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      code_q    <= code_d;
      ill_op_q  <= ill_op_d;
      cy_q      <= cy_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign op_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): vector table plus scoreboard queue,
// with hand-written sequences for back-pressure and mid-operation reset.
module tb_alu_seq;

  localparam int WIDTH = 16;
`ifdef ALU_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             illegal;
  logic             ovf;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_sel    (op_sel),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .illegal   (illegal),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op_sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        il;
    logic        ov;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   tests_run;
  int   tests_failed;

  function automatic vec_t mk(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] r, input logic c, input logic z,
                              input logic il, input logic ov);
    vec_t v;
    v.op_sel = op; v.a = x; v.b = y; v.res = r;
    v.c = c; v.z = z; v.il = il; v.ov = ov;
    return v;
  endfunction

  // Reference behaviour written from plain integer arithmetic.
  function automatic vec_t model(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
    vec_t v;
    logic [16:0] t;
    v = mk(op, x, y, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    case (op)
      8'h80: begin
        t = {1'b0, x} + {1'b0, y};
        v.res = t[15:0]; v.c = t[16];
        v.ov = (x[15] == y[15]) && (t[15] != x[15]);
      end
      8'h40: begin
        v.res = x - y; v.c = (x >= y);
        v.ov = (x[15] != y[15]) && (v.res[15] != x[15]);
      end
      8'h20: v.res = x & y;
      8'h10: v.res = x | y;
      8'h08: v.res = x ^ y;
      8'h04: v.res = ~x;
      8'h02: begin v.res = x + 16'd1; v.c = (x == 16'hFFFF); v.ov = (x == 16'h7FFF); end
      8'h01: begin v.res = x - 16'd1; v.c = (x != 16'h0000); v.ov = (x == 16'h8000); end
      default: v.il = 1'b1;
    endcase
    v.z = (v.res == 16'h0000);
    if (!OVF_ON) v.ov = 1'b0;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    n = 0;
    while (!op_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!op_ready) checkValue("op_ready wait", op_ready, 1);
    op_valid = 1'b1; op_sel = v.op_sel; a = v.a; b = v.b;
    sb.push_back(v);
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_sel = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
    checkValue("op_ready after accept", op_ready, 0);
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      checkValue("scoreboard empty", 1, 0);
    end else begin
      e = sb.pop_front();
      checkValue($sformatf("result op=%0h", e.op_sel), result, e.res);
      checkValue($sformatf("carry op=%0h", e.op_sel), carry, e.c);
      checkValue($sformatf("zero op=%0h", e.op_sel), zero, e.z);
      checkValue($sformatf("illegal op=%0h", e.op_sel), illegal, e.il);
      checkValue($sformatf("ovf op=%0h", e.op_sel), ovf, e.ov);
    end
  endtask

  task automatic releaseResult();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkValue("op_ready after release", op_ready, 1);
    checkValue("res_valid after release", res_valid, 0);
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    applyStimulus(v);
    waitResult(lat);
    checkValue("latency", lat, 4);
    if (res_valid) checkOutput();
    else void'(sb.pop_front());
    releaseResult();
  endtask

  initial begin
    vec_t v;
    vec_t held;
    logic [15:0] snap_res;
    logic [3:0]  snap_flags;
    int lat;
    logic stray;

    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; op_valid = 1'b0; op_sel = 8'h00; a = '0; b = '0; res_ready = 1'b0;

    tbl.push_back(mk(8'h80, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 0));
    tbl.push_back(mk(8'h40, 16'h1234, 16'h1234, 16'h0000, 1, 1, 0, 0));
    tbl.push_back(mk(8'h40, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(8'h02, 16'hFFFF, 16'h5A5A, 16'h0000, 1, 1, 0, 0));
    tbl.push_back(mk(8'h01, 16'h0000, 16'hA5A5, 16'hFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(8'h20, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 0));
    tbl.push_back(mk(8'h10, 16'hF0F0, 16'hFF00, 16'hFFF0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h08, 16'hF0F0, 16'hFF00, 16'h0FF0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h04, 16'hF0F0, 16'hFF00, 16'h0F0F, 0, 0, 0, 0));
    tbl.push_back(mk(8'h00, 16'h1234, 16'h5678, 16'h0000, 0, 1, 1, 0));
    tbl.push_back(mk(8'h03, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 1, 1, 0));
    tbl.push_back(mk(8'h80, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0, OVF_ON));
    tbl.push_back(mk(8'h01, 16'h8000, 16'h0000, 16'h7FFF, 1, 0, 0, OVF_ON));
    tbl.push_back(mk(8'h80, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(model(8'h01 << $urandom_range(0, 7), 16'($urandom), 16'($urandom)));
    end

    repeat (2) @(posedge clk);
    #1;
    checkValue("reset op_ready", op_ready, 1);
    checkValue("reset res_valid", res_valid, 0);
    checkValue("reset result", result, 0);
    checkValue("reset flags", {carry, zero, illegal, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) runVector(tbl[i]);

    // Back-pressure: DONE held for 10 cycles while a competing request is offered.
    held = model(8'h80, 16'h1234, 16'h1111);
    applyStimulus(held);
    waitResult(lat);
    checkValue("hold latency", lat, 4);
    snap_res = result;
    snap_flags = {carry, zero, illegal, ovf};
    op_valid = 1'b1; op_sel = 8'h04; a = 16'hAAAA; b = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkValue("hold res_valid", res_valid, 1);
      checkValue("hold op_ready", op_ready, 0);
      checkValue("hold result", result, snap_res);
      checkValue("hold flags", {carry, zero, illegal, ovf}, snap_flags);
    end
    op_valid = 1'b0;
    checkOutput();
    releaseResult();
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (res_valid || !op_ready) stray = 1'b1;
    end
    checkValue("ignored request not queued", stray, 0);

    // Reset asserted in the middle of CALC discards the operation.
    runVector(model(8'h01, 16'h0000, 16'h0000));
    op_valid = 1'b1; op_sel = 8'h40; a = 16'h1234; b = 16'h1234;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkValue("midreset op_ready", op_ready, 1);
    checkValue("midreset res_valid", res_valid, 0);
    checkValue("midreset result", result, 0);
    checkValue("midreset flags", {carry, zero, illegal, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkValue("post-reset op_ready", op_ready, 1);
    checkValue("post-reset res_valid", res_valid, 0);
    runVector(model(8'h40, 16'h0005, 16'h0003));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: actual running required finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
